// File: rtl/user_input_pkg.sv
// user_input_pkg: shared defaults and sizing helper for the user_input block
package user_input_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 0;

  // Bits needed to count 0..n-1, never less than one bit
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/user_input_sync_chain.sv
// sync_chain: generic async-reset flop chain used as an input synchronizer
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s_q;

  // Shift the raw level in at bit 0; the oldest sample leaves at the top
  always_ff @(posedge clk or negedge reset)
    if (!reset) s_q <= '0;
    else        s_q <= STAGES'({s_q, d});

  assign q = s_q[STAGES-1];

endmodule

// File: rtl/user_input.sv
// user_input: synchronize, optionally debounce, and turn rising edges into one-cycle pulses
module user_input
  import user_input_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic sync_w;
  logic acc_w;
  logic prev_q;
  logic out_q;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (in),
    .q    (sync_w)
  );

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodb
      assign acc_w = sync_w;
    end else begin : g_db
      localparam int CW = clog2_safe(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] cnt_q, cnt_d;
      logic          acc_q, acc_d;
      // Accept a new level only after it has differed for DEBOUNCE_CYCLES straight cycles
      always_comb begin
        acc_d = (sync_w != acc_q && cnt_q == LAST) ? sync_w : acc_q;
        cnt_d = (sync_w == acc_q || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
      // Debounce state; reset discards any partial count
      always_ff @(posedge clk or negedge reset)
        if (!reset) begin
          acc_q <= 1'b0;
          cnt_q <= '0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
        end
      assign acc_w = acc_q;
    end
  endgenerate

  // Registered rising-edge detect so out never depends combinationally on in
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      prev_q <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      prev_q <= acc_w;
      out_q  <= acc_w & ~prev_q;
    end

  assign out = out_q;

endmodule

// File: tb/tb_user_input.sv
// tb_user_input: scoreboard bench for three user_input configurations
module tb_user_input;

  logic clk = 1'b0;
  logic reset;
  logic in_a, in_b, in_c;
  logic out_a, out_b, out_c;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   pulses_a = 0;
  int   qa[$];
  int   qb[$];
  int   qc[$];

  // a: SYNC=2 D=0, b: SYNC=2 D=3, c: SYNC=1 D=0
  user_input #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut_a (.clk(clk), .reset(reset), .in(in_a), .out(out_a));
  user_input #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(3)) dut_b (.clk(clk), .reset(reset), .in(in_b), .out(out_b));
  user_input #(.SYNC_STAGES(1), .DEBOUNCE_CYCLES(0)) dut_c (.clk(clk), .reset(reset), .in(in_c), .out(out_c));

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every observed pulse must match the next expected pulse cycle; -1 marks an unexpected pulse
  always @(negedge clk) begin
    if (out_a === 1'b1) begin
      pulses_a++;
      check("a_pulse_cycle", cyc, qa.size() > 0 ? qa.pop_front() : -1);
    end
    if (out_b === 1'b1) check("b_pulse_cycle", cyc, qb.size() > 0 ? qb.pop_front() : -1);
    if (out_c === 1'b1) check("c_pulse_cycle", cyc, qc.size() > 0 ? qc.pop_front() : -1);
  end

  initial begin
    int p0;
    reset = 1'b0;
    in_a  = 1'b1;
    in_b  = 1'b1;
    in_c  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_out_a", out_a, 0);
      check("rst_out_b", out_b, 0);
      check("rst_out_c", out_c, 0);
    end
    reset = 1'b1;
    qa.push_back(cyc + 3);
    qb.push_back(cyc + 6);
    qc.push_back(cyc + 2);
    step(12);
    in_a = 1'b0;
    in_b = 1'b0;
    in_c = 1'b0;
    step(8);
    in_a = 1'b1;
    qa.push_back(cyc + 3);
    step(10);
    in_a = 1'b0;
    step(1);
    in_a = 1'b1;
    qa.push_back(cyc + 3);
    step(6);
    in_a = 1'b0;
    step(6);
    p0 = pulses_a;
    for (int i = 0; i < 40; i++) begin
      in_a = (i % 8) < 4;
      if (i % 8 == 0) qa.push_back(cyc + 3);
      step(1);
    end
    in_a = 1'b0;
    step(6);
    check("square_pulse_count", pulses_a - p0, 5);
    in_b = 1'b1;
    step(2);
    in_b = 1'b0;
    step(8);
    in_b = 1'b1;
    qb.push_back(cyc + 6);
    step(5);
    in_b = 1'b0;
    step(10);
    in_a = 1'b1;
    in_b = 1'b1;
    qa.push_back(cyc + 3);
    step(3);
    check("pre_reset_out_a", out_a, 1);
    #1 reset = 1'b0;
    in_a = 1'b0;
    #1 check("async_reset_out_a", out_a, 0);
    check("async_reset_out_b", out_b, 0);
    step(2);
    reset = 1'b1;
    qb.push_back(cyc + 6);
    step(12);
    in_b = 1'b0;
    step(8);
    in_c = 1'b1;
    qc.push_back(cyc + 2);
    step(6);
    in_c = 1'b0;
    step(8);
    check("a_pending_left", qa.size(), 0);
    check("b_pending_left", qb.size(), 0);
    check("c_pending_left", qc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
